// File: rtl/pacoblaze_intc.sv
// Eight-way interrupt controller for the PacoBlaze3 port bus: synchronizes requests, resolves priority, runs the raise/ack/EOI handshake.
// Define PACOBLAZE_INTC_ROTATE_EN for round-robin priority; the default build uses fixed lowest-index priority.
module pacoblaze_intc #(
   parameter int         SOURCES   = 8,
   parameter logic [7:0] BASE_ADDR = 8'hF0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SOURCES-1:0] irq_src,
   input  logic [7:0]         port_id,
   input  logic               write_strobe,
   input  logic               read_strobe,
   input  logic [7:0]         out_port,
   output logic [7:0]         in_data,
   output logic               interrupt,
   input  logic               interrupt_ack
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RAISE   = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   logic [SOURCES-1:0] s1_r, s2_r, s3_r;
   logic [SOURCES-1:0] pend_r, mask_r, edge_r;
   logic [SOURCES-1:0] pend_nxt_s, elig_s;
   state_t             state_r, state_nxt_s;
   logic               interrupt_r, interrupt_nxt_s;
   logic [2:0]         cand_r, cand_nxt_s;
   logic [2:0]         vec_id_r, vec_id_nxt_s;
   logic               vec_valid_r, vec_valid_nxt_s;
   logic [2:0]         winner_s;
   logic               any_elig_s;
   logic [7:0]         off_s;
   logic               wr_pend_s, wr_mask_s, wr_vec_s, wr_edge_s;
   logic               ack_take_s, eoi_s;
   logic               unused_s;

   // read_strobe carries no state effect; reads are side-effect free
   assign unused_s  = ^{read_strobe, out_port};
   assign interrupt = interrupt_r;

   // Register-window decode relative to BASE_ADDR
   always_comb begin
      off_s      = port_id - BASE_ADDR;
      wr_pend_s  = write_strobe && (off_s == 8'd0);
      wr_mask_s  = write_strobe && (off_s == 8'd1);
      wr_vec_s   = write_strobe && (off_s == 8'd2);
      wr_edge_s  = write_strobe && (off_s == 8'd3);
      ack_take_s = (state_r == ST_RAISE) && interrupt_ack;
      eoi_s      = (state_r == ST_SERVICE) && wr_vec_s;
      elig_s     = pend_r & mask_r;
      any_elig_s = |elig_s;
   end

   // Pending update: level bits mirror s2; edge bits are sticky, and a fresh edge beats any clear
   always_comb begin
      pend_nxt_s = pend_r;
      for (int i = 0; i < SOURCES; i++) begin
         if (edge_r[i]) begin
            pend_nxt_s[i] = (s2_r[i] & ~s3_r[i]) |
                            (pend_r[i] & ~((wr_pend_s & out_port[i]) |
                                           (ack_take_s && (cand_r == 3'(i)))));
         end else begin
            pend_nxt_s[i] = s2_r[i];
         end
      end
   end

`ifdef PACOBLAZE_INTC_ROTATE_EN
   logic [2:0] rr_r, rr_nxt_s;

   // Round-robin pick: smallest forward distance from rr wins
   always_comb begin : pick_rr
      int best;
      int dist;
      logic take;
      best     = SOURCES;
      dist     = 0;
      take     = 1'b0;
      winner_s = 3'd0;
      for (int i = 0; i < SOURCES; i++) begin
         dist     = (i >= int'(rr_r)) ? (i - int'(rr_r)) : (i + SOURCES - int'(rr_r));
         take     = elig_s[i] && (dist < best);
         best     = take ? dist : best;
         winner_s = take ? 3'(i) : winner_s;
      end
   end

   // Pointer advances past the source just serviced
   always_comb begin
      if (eoi_s) begin
         rr_nxt_s = (vec_id_r == 3'(SOURCES - 1)) ? 3'd0 : vec_id_r + 3'd1;
      end else begin
         rr_nxt_s = rr_r;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_r <= 3'd0;
      end else begin
         rr_r <= rr_nxt_s;
      end
   end
`else
   // Fixed priority: scan downward so the lowest eligible index is left standing
   always_comb begin
      winner_s = 3'd0;
      for (int i = SOURCES - 1; i >= 0; i--) begin
         winner_s = elig_s[i] ? 3'(i) : winner_s;
      end
   end
`endif

   // Handshake FSM next-state; interrupt stays up in RAISE whatever PEND/MASK do
   always_comb begin
      state_nxt_s     = state_r;
      interrupt_nxt_s = 1'b0;
      cand_nxt_s      = cand_r;
      vec_valid_nxt_s = vec_valid_r;
      vec_id_nxt_s    = vec_id_r;
      case (state_r)
         ST_IDLE: begin
            if (any_elig_s) begin
               state_nxt_s     = ST_RAISE;
               interrupt_nxt_s = 1'b1;
               cand_nxt_s      = winner_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RAISE: begin
            if (ack_take_s) begin
               state_nxt_s     = ST_SERVICE;
               vec_valid_nxt_s = 1'b1;
               vec_id_nxt_s    = cand_r;
            end else begin
               interrupt_nxt_s = 1'b1;
            end
         end
         ST_SERVICE: begin
            if (eoi_s) begin
               state_nxt_s     = ST_IDLE;
               vec_valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_SERVICE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // All controller state: synchronizers, registers, FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r        <= '0;
         s2_r        <= '0;
         s3_r        <= '0;
         pend_r      <= '0;
         mask_r      <= '0;
         edge_r      <= '0;
         state_r     <= ST_IDLE;
         interrupt_r <= 1'b0;
         cand_r      <= 3'd0;
         vec_valid_r <= 1'b0;
         vec_id_r    <= 3'd0;
      end else begin
         s1_r        <= irq_src;
         s2_r        <= s1_r;
         s3_r        <= s2_r;
         pend_r      <= pend_nxt_s;
         mask_r      <= wr_mask_s ? out_port[SOURCES-1:0] : mask_r;
         edge_r      <= wr_edge_s ? out_port[SOURCES-1:0] : edge_r;
         state_r     <= state_nxt_s;
         interrupt_r <= interrupt_nxt_s;
         cand_r      <= cand_nxt_s;
         vec_valid_r <= vec_valid_nxt_s;
         vec_id_r    <= vec_id_nxt_s;
      end
   end

   // Zero-latency read mux; unused high bits and out-of-window addresses read 0
   always_comb begin
      in_data = 8'h00;
      case (off_s)
         8'd0:    in_data[SOURCES-1:0] = pend_r;
         8'd1:    in_data[SOURCES-1:0] = mask_r;
         8'd2:    in_data = {vec_valid_r, 4'b0000, vec_id_r};
         8'd3:    in_data[SOURCES-1:0] = edge_r;
         default: in_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_pacoblaze_intc.sv
// Self-checking bench for pacoblaze_intc: directed handshake scenarios plus random traffic against a cycle model.
// Honours PACOBLAZE_INTC_ROTATE_EN the same way the design does.
module tb_pacoblaze_intc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] irq_src = 8'h00;
   logic [7:0] port_id = 8'h00;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] out_port = 8'h00;
   logic [7:0] in_data;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   pacoblaze_intc #(.SOURCES(8), .BASE_ADDR(8'hF0)) dut (
      .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .port_id(port_id),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .out_port(out_port),
      .in_data(in_data), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
   );

   always #5 clk = ~clk;

   // Behavioural model: sample history, register file, handshake phase
   logic [7:0] m_s1, m_s2, m_s3, m_pend, m_mask, m_edge;
   int         m_phase, m_cand, m_vid, m_rr;
   logic       m_vv, m_int;

   task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00;
      m_pend = 8'h00; m_mask = 8'h00; m_edge = 8'h00;
      m_phase = 0; m_cand = 0; m_vid = 0; m_rr = 0;
      m_vv = 1'b0; m_int = 1'b0;
   endtask

   function automatic int m_pick(input logic [7:0] e);
`ifdef PACOBLAZE_INTC_ROTATE_EN
      for (int k = 0; k < 8; k++) begin
         if (e[(m_rr + k) % 8]) return (m_rr + k) % 8;
      end
`else
      for (int k = 0; k < 8; k++) begin
         if (e[k]) return k;
      end
`endif
      return -1;
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'hF0:   return m_pend;
         8'hF1:   return m_mask;
         8'hF2:   return {m_vv, 4'b0000, 3'(m_vid)};
         8'hF3:   return m_edge;
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_edge_update();
      logic [7:0] np;
      logic       hp, hm, hv, he, setb, clrb;
      int         w;
      hp = write_strobe && (port_id == 8'hF0);
      hm = write_strobe && (port_id == 8'hF1);
      hv = write_strobe && (port_id == 8'hF2);
      he = write_strobe && (port_id == 8'hF3);
      np = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (m_edge[i]) begin
            setb  = m_s2[i] && !m_s3[i];
            clrb  = (hp && out_port[i]) || (m_phase == 1 && interrupt_ack && m_cand == i);
            np[i] = setb || (m_pend[i] && !clrb);
         end else begin
            np[i] = m_s2[i];
         end
      end
      case (m_phase)
         0: begin
            w = m_pick(m_pend & m_mask);
            if (w >= 0) begin m_cand = w; m_phase = 1; m_int = 1'b1; end
         end
         1: if (interrupt_ack) begin m_int = 1'b0; m_vv = 1'b1; m_vid = m_cand; m_phase = 2; end
         2: if (hv) begin m_vv = 1'b0; m_rr = (m_vid + 1) % 8; m_phase = 0; end
         default: ;
      endcase
      if (hm) m_mask = out_port;
      if (he) m_edge = out_port;
      m_pend = np;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_src;
   endtask

   // One clock: model steps with the DUT, outputs compared on the falling edge
   task automatic step();
      @(posedge clk);
      m_edge_update();
      @(negedge clk);
      check_value("intr", {7'b0, interrupt}, {7'b0, m_int});
      check_value("rd", in_data, m_read(port_id));
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id = a; out_port = d; write_strobe = 1'b1;
      step();
      write_strobe = 1'b0; out_port = 8'h00;
   endtask

   task automatic ack_pulse();
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
      port_id = a; write_strobe = 1'b0;
      #1;
      check_value(tag, in_data, exp);
   endtask

   task automatic wait_irq(input string tag);
      int n = 0;
      while (interrupt !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_value(tag, {7'b0, interrupt}, 8'h01);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; irq_src = 8'h00; write_strobe = 1'b0; interrupt_ack = 1'b0;
      #1;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] addrs [6];
      logic [7:0] exp_id;
      int         r;
      addrs = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h00};
      m_reset();
      #1 rst_n = 1'b0;
      #2;
      check_value("rst_intr", {7'b0, interrupt}, 8'h00);
      read_chk("rst_pend", 8'hF0, 8'h00);
      read_chk("rst_mask", 8'hF1, 8'h00);
      read_chk("rst_vec",  8'hF2, 8'h00);
      read_chk("rst_edge", 8'hF3, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Single edge source: latency and ack/EOI vector
      wr(8'hF1, 8'h04);
      wr(8'hF3, 8'h04);
      irq_src = 8'h04;
      step();
      irq_src = 8'h00;
      step();
      step();
      check_value("lat_e2", {7'b0, interrupt}, 8'h00);
      step();
      check_value("lat_e3", {7'b0, interrupt}, 8'h01);
      ack_pulse();
      read_chk("ack_vec", 8'hF2, 8'h82);
      read_chk("ack_pend", 8'hF0, 8'h00);
      wr(8'hF2, 8'($urandom));
      read_chk("eoi_vec", 8'hF2, 8'h02);

      // Two simultaneous edges: lower index first
      wr(8'hF1, 8'hFF);
      wr(8'hF3, 8'hFF);
      irq_src = 8'h22;
      step();
      irq_src = 8'h00;
      wait_irq("pri_up1");
      ack_pulse();
      read_chk("pri_vec1", 8'hF2, 8'h81);
      wr(8'hF2, 8'h00);
      wait_irq("pri_up2");
      ack_pulse();
      read_chk("pri_vec2", 8'hF2, 8'h85);
      wr(8'hF2, 8'h00);

      // Masked pending, late unmask, W1C colliding with a new edge
      wr(8'hF1, 8'h00);
      wr(8'hF3, 8'h08);
      irq_src = 8'h08;
      step();
      irq_src = 8'h00;
      repeat (5) step();
      check_value("masked", {7'b0, interrupt}, 8'h00);
      read_chk("masked_pend", 8'hF0, 8'h08);
      wr(8'hF1, 8'h08);
      step();
      check_value("unmask_1edge", {7'b0, interrupt}, 8'h01);
      ack_pulse();
      read_chk("acked_pend", 8'hF0, 8'h00);
      irq_src = 8'h08;
      step();
      irq_src = 8'h00;
      step();
      wr(8'hF0, 8'h08);
      read_chk("set_wins", 8'hF0, 8'h08);
      wr(8'hF2, 8'h00);
      wait_irq("set_wins_up");
      ack_pulse();
      wr(8'hF2, 8'h00);

      // Level source held through EOI: W1C ignored, two-edge re-raise
      wr(8'hF3, 8'h00);
      wr(8'hF1, 8'h01);
      irq_src = 8'h01;
      wait_irq("lvl_up");
      ack_pulse();
      wr(8'hF0, 8'h01);
      read_chk("lvl_w1c", 8'hF0, 8'h01);
      wr(8'hF2, 8'h00);
      check_value("lvl_gap", {7'b0, interrupt}, 8'h00);
      step();
      check_value("lvl_rearm", {7'b0, interrupt}, 8'h01);
      ack_pulse();
      irq_src = 8'h00;
      wr(8'hF2, 8'h00);
      repeat (4) step();

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
         end
         r = int'($urandom_range(0, 15));
         out_port = 8'($urandom);
         write_strobe = 1'b0;
         if (r < 4) begin
            port_id = addrs[r];
            write_strobe = 1'b1;
         end else begin
            port_id = addrs[$urandom_range(0, 5)];
         end
         interrupt_ack = ($urandom_range(0, 3) == 0);
         read_strobe = 1'($urandom_range(0, 1));
         step();
      end
      write_strobe = 1'b0; interrupt_ack = 1'b0; read_strobe = 1'b0;

      // Asynchronous reset while the request is raised
      do_reset();
      wr(8'hF1, 8'h01);
      wr(8'hF3, 8'h01);
      irq_src = 8'h01;
      step();
      irq_src = 8'h00;
      wait_irq("ar_up");
      #2 rst_n = 1'b0;
      #1;
      check_value("ar_drop", {7'b0, interrupt}, 8'h00);
      read_chk("ar_mask", 8'hF1, 8'h00);
      read_chk("ar_edge", 8'hF3, 8'h00);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();

      // Two level sources held: service order shows the priority policy
      wr(8'hF1, 8'h03);
      irq_src = 8'h03;
      for (int k = 0; k < 4; k++) begin
         wait_irq("rot_up");
         ack_pulse();
`ifdef PACOBLAZE_INTC_ROTATE_EN
         exp_id = 8'(k % 2);
`else
         exp_id = 8'h00;
`endif
         read_chk("rot_id", 8'hF2, 8'h80 | exp_id);
         wr(8'hF2, 8'h00);
      end
      irq_src = 8'h00;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
